xbar_id_order_tracker: RTL

- Per-master outstanding-transaction tracker for the crossbar master-side interface; one instance per direction (AR/R or AW/B).
- Replaces the single-bit "one outstanding per ID" table with per-ID counters plus a per-ID locked destination slave.
- Allows multiple in-flight transactions with the same ID while preserving AXI same-ID ordering: all outstanding transactions of one ID must target the same slave.
- Adds a global outstanding cap and sticky protocol-error flags.

---
 rtl/xbar_id_order_tracker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xbar_id_order_tracker.sv
// Purpose : per-master outstanding-transaction tracker; per-ID counters with a locked destination slave, plus a global cap.
// Latency : req_allow/block_reason combinational from registered state; issue/completion visible one cycle after the edge.
// Backpr. : req_allow=0 holds the head request in the master FIFO; completions are never stalled.
//
// Ports:
//   ACLK, ARESETn                       clock, asynchronous active-low reset
//   req_valid/req_id/req_dest_slave     head-of-FIFO address request
//   req_allow, block_reason             forwarding permission and reason when blocked (0 idle/allowed, 1 dest, 2 per-ID, 3 total)
//   req_issue                           head request popped and forwarded this cycle
//   cpl_valid/cpl_last/cpl_id           response beat pushed to the master return FIFO
//   total_outstanding, busy             registered global outstanding count and non-zero flag
//   err_underflow, err_illegal_issue    sticky protocol-error flags
module xbar_id_order_tracker #(
    parameter int ID_WIDTH   = 4,
    parameter int slaves     = 2,
    parameter int MAX_PER_ID = 4,
    parameter int MAX_TOTAL  = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    input  logic                             req_valid,
    input  logic [ID_WIDTH-1:0]              req_id,
    input  logic [$clog2(slaves)-1:0]        req_dest_slave,
    output logic                             req_allow,
    output logic [1:0]                       block_reason,
    input  logic                             req_issue,
    input  logic                             cpl_valid,
    input  logic                             cpl_last,
    input  logic [ID_WIDTH-1:0]              cpl_id,
    output logic [$clog2(MAX_TOTAL+1)-1:0]   total_outstanding,
    output logic                             busy,
    output logic                             err_underflow,
    output logic                             err_illegal_issue
);

    localparam int IDS = 2 ** ID_WIDTH;
    localparam int DW  = $clog2(slaves);
    localparam int CW  = $clog2(MAX_PER_ID + 1);
    localparam int TW  = $clog2(MAX_TOTAL + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PER_ID);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [TW-1:0] TOT_MAX = TW'(MAX_TOTAL);
    localparam logic [TW-1:0] TOT_ONE = TW'(1);

    logic [CW-1:0]  r_cnt   [IDS];
    logic [DW-1:0]  r_dest  [IDS];
    logic [TW-1:0]  r_total;
    logic           r_err_underflow;
    logic           r_err_illegal_issue;

    logic [CW-1:0]  w_cnt_req;
    logic           w_id_idle;
    logic           w_dest_match;
    logic           w_id_full;
    logic           w_total_full;
    logic           w_allow;
    logic           w_issue;
    logic           w_cpl_hit;
    logic           w_cpl;
    logic [IDS-1:0] w_inc;
    logic [IDS-1:0] w_dec;

    // Allow decision uses registered state only; a completion in the same
    // cycle frees its slot on the following cycle, never combinationally.
    assign w_cnt_req    = r_cnt[req_id];
    assign w_id_idle    = (w_cnt_req == '0);
    assign w_dest_match = (r_dest[req_id] == req_dest_slave);
    assign w_id_full    = (w_cnt_req == CNT_MAX);
    assign w_total_full = (r_total == TOT_MAX);

    assign w_allow   = req_valid & ~w_total_full & (w_id_idle | (w_dest_match & ~w_id_full));
    assign req_allow = w_allow;

    always_comb begin
        block_reason = 2'd0;
        if (req_valid && !w_allow) begin
            if (w_total_full)
                block_reason = 2'd3;
            else if (!w_id_idle && !w_dest_match)
                block_reason = 2'd1;
            else if (w_id_full)
                block_reason = 2'd2;
        end
    end

    assign w_issue   = req_issue & w_allow;
    assign w_cpl_hit = cpl_valid & cpl_last;
    // Completions against an idle ID are dropped so counters never wrap.
    assign w_cpl     = w_cpl_hit & (r_cnt[cpl_id] != '0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_issue) w_inc[req_id] = 1'b1;
        if (w_cpl)   w_dec[cpl_id] = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < IDS; i++) begin
                r_cnt[i]  <= '0;
                r_dest[i] <= '0;
            end
            r_total             <= '0;
            r_err_underflow     <= 1'b0;
            r_err_illegal_issue <= 1'b0;
        end else begin
            for (int i = 0; i < IDS; i++) begin
                // Same-ID issue and completion cancel out.
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                else if (w_dec[i] && !w_inc[i])
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
                // Destination locks on the first outstanding transaction only.
                if (w_inc[i] && (r_cnt[i] == '0))
                    r_dest[i] <= req_dest_slave;
            end
            if (w_issue && !w_cpl)
                r_total <= r_total + TOT_ONE;
            else if (w_cpl && !w_issue)
                r_total <= r_total - TOT_ONE;
            if (w_cpl_hit && (r_cnt[cpl_id] == '0))
                r_err_underflow <= 1'b1;
            if (req_issue && !w_allow)
                r_err_illegal_issue <= 1'b1;
        end
    end

    assign total_outstanding = r_total;
    assign busy              = (r_total != '0);
    assign err_underflow     = r_err_underflow;
    assign err_illegal_issue = r_err_illegal_issue;

endmodule
